// File: rtl/cdb_arbiter_if.sv
// Bundles the producer result ports, the flush/enable controls and the registered CDB broadcast.
interface cdb_arbiter_if #(
    parameter int unsigned ROB_WIDTH = 4
) ();
    logic                 readyIn;
    logic                 clearFlag;

    logic                 aluFlag;
    logic [31:0]          aluVal;
    logic [ROB_WIDTH-1:0] aluDest;
    logic                 aluFull;

    logic                 lsbFlag;
    logic [31:0]          lsbVal;
    logic [ROB_WIDTH-1:0] lsbDest;
    logic                 lsbFull;

    logic                 cdbFlag;
    logic [31:0]          cdbVal;
    logic [ROB_WIDTH-1:0] cdbDest;
    logic                 cdbSrc;

    // Producer / consumer side: drives results and controls, observes CDB and full flags.
    modport master (
        output readyIn, clearFlag,
        output aluFlag, aluVal, aluDest,
        output lsbFlag, lsbVal, lsbDest,
        input  aluFull, lsbFull,
        input  cdbFlag, cdbVal, cdbDest, cdbSrc
    );

    // Arbiter side.
    modport slave (
        input  readyIn, clearFlag,
        input  aluFlag, aluVal, aluDest,
        input  lsbFlag, lsbVal, lsbDest,
        output aluFull, lsbFull,
        output cdbFlag, cdbVal, cdbDest, cdbSrc
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs with bypass, round-robin grant,
// registered CDB broadcast stage. Source index 0 = ALU, 1 = LSB.
module cdb_arbiter #(
    parameter int unsigned ROB_WIDTH   = 4,
    parameter int unsigned QUEUE_WIDTH = 2
) (
    input  logic         clockIn,
    input  logic         resetIn,
    cdb_arbiter_if.slave bus
);
    localparam int unsigned QSIZE = 1 << QUEUE_WIDTH;
    localparam int unsigned CW    = QUEUE_WIDTH + 1;
    localparam int unsigned NSRC  = 2;
    localparam logic [QUEUE_WIDTH-1:0] PTR_ONE = QUEUE_WIDTH'(1);

    typedef struct packed {
        logic [31:0]          val;
        logic [ROB_WIDTH-1:0] dest;
    } entry_t;

    entry_t                 mem   [NSRC][QSIZE];
    logic [QUEUE_WIDTH-1:0] head  [NSRC];
    logic [QUEUE_WIDTH-1:0] tail  [NSRC];
    logic [CW-1:0]          count [NSRC];
    logic                   lastGrant;

    logic   cdbFlagQ;
    entry_t cdbQ;
    logic   cdbSrcQ;

    logic [NSRC-1:0] inFlag;
    entry_t          inEntry   [NSRC];
    entry_t          candEntry [NSRC];
    logic [NSRC-1:0] hasQ;
    logic [NSRC-1:0] cand;
    logic [NSRC-1:0] pop;
    logic [NSRC-1:0] bypass;
    logic [NSRC-1:0] push;
    logic            grantAny;
    logic            grantSrc;
    entry_t          winEntry;

    // Gather producer inputs into per-source form.
    always_comb begin
        inFlag[0]  = bus.aluFlag;
        inFlag[1]  = bus.lsbFlag;
        inEntry[0] = '{val: bus.aluVal, dest: bus.aluDest};
        inEntry[1] = '{val: bus.lsbVal, dest: bus.lsbDest};
    end

    // Candidate selection, round-robin grant and per-queue pop/bypass/push decisions.
    always_comb begin
        hasQ      = '0;
        cand      = '0;
        pop       = '0;
        bypass    = '0;
        push      = '0;
        candEntry = inEntry;
        for (int s = 0; s < NSRC; s++) begin
            hasQ[s]      = (count[s] != '0);
            cand[s]      = hasQ[s] | inFlag[s];
            candEntry[s] = hasQ[s] ? mem[s][head[s]] : inEntry[s];
        end
        grantAny = |cand;
        // On a tie the source that did not win last time goes; otherwise the lone requester.
        grantSrc = (&cand) ? ~lastGrant : cand[1];
        winEntry = candEntry[grantSrc];
        for (int s = 0; s < NSRC; s++) begin
            pop[s]    = grantAny && (grantSrc == 1'(s)) && hasQ[s];
            bypass[s] = grantAny && (grantSrc == 1'(s)) && !hasQ[s];
            // A push into a completely full queue is dropped.
            push[s]   = inFlag[s] && !bypass[s] && (count[s] != CW'(QSIZE));
        end
    end

    // Queue pointers, round-robin history and the registered CDB stage.
    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            for (int s = 0; s < NSRC; s++) begin
                head[s]  <= '0;
                tail[s]  <= '0;
                count[s] <= '0;
            end
            lastGrant <= 1'b1;
            cdbFlagQ  <= 1'b0;
            cdbQ      <= '0;
            cdbSrcQ   <= 1'b0;
        end else if (bus.clearFlag) begin
            for (int s = 0; s < NSRC; s++) begin
                head[s]  <= '0;
                tail[s]  <= '0;
                count[s] <= '0;
            end
            cdbFlagQ <= 1'b0;
        end else if (bus.readyIn) begin
            for (int s = 0; s < NSRC; s++) begin
                if (push[s]) begin
                    mem[s][tail[s]] <= inEntry[s];
                    tail[s]         <= tail[s] + PTR_ONE;
                end
                if (pop[s]) begin
                    head[s] <= head[s] + PTR_ONE;
                end
                count[s] <= count[s] + CW'(push[s]) - CW'(pop[s]);
            end
            if (grantAny) begin
                lastGrant <= grantSrc;
                cdbFlagQ  <= 1'b1;
                cdbQ      <= winEntry;
                cdbSrcQ   <= grantSrc;
            end else begin
                cdbFlagQ <= 1'b0;
            end
        end
    end

    // Outputs: CDB straight from its register, full flags decoded from the registered counts.
    assign bus.cdbFlag = cdbFlagQ;
    assign bus.cdbVal  = cdbQ.val;
    assign bus.cdbDest = cdbQ.dest;
    assign bus.cdbSrc  = cdbSrcQ;
    assign bus.aluFull = (count[0] >= CW'(QSIZE - 1));
    assign bus.lsbFull = (count[1] >= CW'(QSIZE - 1));
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-level reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_cdb_arbiter;
    localparam int unsigned ROB   = 4;
    localparam int unsigned QW    = 2;
    localparam int unsigned QSIZE = 1 << QW;

    typedef logic [31+ROB:0] ent_t;

    logic clockIn = 1'b0;
    logic resetIn = 1'b1;
    int   checks  = 0;
    int   errors  = 0;
    bit   cmpEn   = 1'b0;

    cdb_arbiter_if #(.ROB_WIDTH(ROB)) bus ();

    cdb_arbiter #(.ROB_WIDTH(ROB), .QUEUE_WIDTH(QW)) dut (
        .clockIn (clockIn),
        .resetIn (resetIn),
        .bus     (bus)
    );

    always #5 clockIn = ~clockIn;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain queues per source, updated on each rising edge.
    ent_t     mq0[$];
    ent_t     mq1[$];
    bit       mLast;
    bit       mFlag;
    bit [31:0] mVal;
    bit [ROB-1:0] mDest;
    bit       mSrc;
    bit       c0, c1, g, byp0, byp1;
    int       s0, s1;
    ent_t     e;

    always @(posedge clockIn) begin
        if (resetIn) begin
            mq0.delete(); mq1.delete();
            mLast = 1'b1; mFlag = 1'b0; mVal = '0; mDest = '0; mSrc = 1'b0;
        end else if (bus.clearFlag) begin
            mq0.delete(); mq1.delete();
            mFlag = 1'b0;
        end else if (bus.readyIn) begin
            s0 = mq0.size(); s1 = mq1.size();
            c0 = (s0 != 0) || bus.aluFlag;
            c1 = (s1 != 0) || bus.lsbFlag;
            byp0 = 1'b0; byp1 = 1'b0;
            if (c0 || c1) begin
                g = (c0 && c1) ? !mLast : c1;
                if (!g) begin
                    if (s0 != 0) e = mq0.pop_front();
                    else begin e = {bus.aluVal, bus.aluDest}; byp0 = 1'b1; end
                end else begin
                    if (s1 != 0) e = mq1.pop_front();
                    else begin e = {bus.lsbVal, bus.lsbDest}; byp1 = 1'b1; end
                end
                mFlag = 1'b1; mVal = e[31+ROB:ROB]; mDest = e[ROB-1:0]; mSrc = g; mLast = g;
            end else begin
                mFlag = 1'b0;
            end
            if (bus.aluFlag && !byp0) begin
                chk("alu_push_not_full", 32'(s0 == QSIZE), 32'd0);
                if (s0 != QSIZE) mq0.push_back({bus.aluVal, bus.aluDest});
            end
            if (bus.lsbFlag && !byp1) begin
                chk("lsb_push_not_full", 32'(s1 == QSIZE), 32'd0);
                if (s1 != QSIZE) mq1.push_back({bus.lsbVal, bus.lsbDest});
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clockIn) begin
        if (cmpEn) begin
            chk("m_cdbFlag", 32'(bus.cdbFlag), 32'(mFlag));
            chk("m_cdbVal",  bus.cdbVal,       mVal);
            chk("m_cdbDest", 32'(bus.cdbDest), 32'(mDest));
            chk("m_cdbSrc",  32'(bus.cdbSrc),  32'(mSrc));
            chk("m_aluFull", 32'(bus.aluFull), 32'(mq0.size() >= QSIZE - 1));
            chk("m_lsbFull", 32'(bus.lsbFull), 32'(mq1.size() >= QSIZE - 1));
        end
    end

    task automatic tick();
        @(posedge clockIn);
        #1;
    endtask

    task automatic idle_inputs();
        bus.aluFlag = 1'b0; bus.aluVal = '0; bus.aluDest = '0;
        bus.lsbFlag = 1'b0; bus.lsbVal = '0; bus.lsbDest = '0;
        bus.clearFlag = 1'b0; bus.readyIn = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetIn = 1'b1;
        tick(); tick();
        resetIn = 1'b0;
    endtask

    task automatic set_alu(input bit f, input logic [31:0] v, input logic [ROB-1:0] d);
        bus.aluFlag = f; bus.aluVal = v; bus.aluDest = d;
    endtask

    task automatic set_lsb(input bit f, input logic [31:0] v, input logic [ROB-1:0] d);
        bus.lsbFlag = f; bus.lsbVal = v; bus.lsbDest = d;
    endtask

    task automatic chk_cdb(input string name, input bit f, input logic [31:0] v,
                           input logic [ROB-1:0] d, input bit s);
        chk({name, "_flag"}, 32'(bus.cdbFlag), 32'(f));
        chk({name, "_val"},  bus.cdbVal,       v);
        chk({name, "_dest"}, 32'(bus.cdbDest), 32'(d));
        chk({name, "_src"},  32'(bus.cdbSrc),  32'(s));
    endtask

    bit sawFull;

    initial begin
        idle_inputs();
        resetIn = 1'b1;
        tick();
        cmpEn = 1'b1;
        tick();
        resetIn = 1'b0;

        // 1. Reset state, idle stays idle.
        chk_cdb("rst", 1'b0, 32'h0, 4'd0, 1'b0);
        chk("rst_aluFull", 32'(bus.aluFull), 32'd0);
        chk("rst_lsbFull", 32'(bus.lsbFull), 32'd0);
        tick();
        chk("idle_flag", 32'(bus.cdbFlag), 32'd0);

        // 2. Bypass on empty queues: one-cycle latency, then flag drops with value held.
        set_alu(1'b1, 32'h11, 4'd3);
        tick();
        chk_cdb("byp", 1'b1, 32'h11, 4'd3, 1'b0);
        set_alu(1'b0, 32'h0, 4'd0);
        tick();
        chk_cdb("byp_after", 1'b0, 32'h11, 4'd3, 1'b0);

        // 3. Tie right after reset: ALU first, then LSB.
        do_reset();
        set_alu(1'b1, 32'hA, 4'd1);
        set_lsb(1'b1, 32'hB, 4'd2);
        tick();
        chk_cdb("tie1", 1'b1, 32'hA, 4'd1, 1'b0);
        idle_inputs();
        tick();
        chk_cdb("tie2", 1'b1, 32'hB, 4'd2, 1'b1);
        tick();
        chk("tie_idle", 32'(bus.cdbFlag), 32'd0);

        // 4. Fill and wrap with producers honouring full flags.
        do_reset();
        sawFull = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sawFull |= bus.aluFull | bus.lsbFull;
            set_alu(!bus.aluFull, 32'h100 + 32'(i), 4'(i));
            set_lsb(!bus.lsbFull, 32'h200 + 32'(i), 4'(i + 8));
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 10; i++) tick();
        chk("fill_sawFull", 32'(sawFull), 32'd1);
        chk("fill_drained", 32'(bus.cdbFlag), 32'd0);
        chk("fill_aluFull_end", 32'(bus.aluFull), 32'd0);

        // 5. Flush with three ALU entries queued and an LSB push in the flush cycle.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_alu(!bus.aluFull, 32'h500 + 32'(i), 4'(i));
            set_lsb(!bus.lsbFull, 32'h580 + 32'(i), 4'(i + 8));
            tick();
        end
        chk("pre_flush_aluFull", 32'(bus.aluFull), 32'd1);
        set_alu(1'b0, 32'h0, 4'd0);
        set_lsb(1'b1, 32'hDEAD, 4'd15);
        bus.clearFlag = 1'b1;
        tick();
        idle_inputs();
        chk("flush_flag", 32'(bus.cdbFlag), 32'd0);
        chk("flush_aluFull", 32'(bus.aluFull), 32'd0);
        chk("flush_lsbFull", 32'(bus.lsbFull), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_idle", 32'(bus.cdbFlag), 32'd0);
        end

        // 6. Stall for 4 cycles with one entry queued per source.
        do_reset();
        set_alu(1'b1, 32'h61, 4'd1); set_lsb(1'b1, 32'h71, 4'd2);
        tick();
        chk_cdb("st_c0", 1'b1, 32'h61, 4'd1, 1'b0);
        set_alu(1'b1, 32'h62, 4'd3); set_lsb(1'b1, 32'h72, 4'd4);
        tick();
        chk_cdb("st_c1", 1'b1, 32'h71, 4'd2, 1'b1);
        bus.readyIn = 1'b0;
        set_alu(1'b1, 32'hBAD, 4'd9); set_lsb(1'b1, 32'hBAD, 4'd9);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_cdb("stall", 1'b1, 32'h71, 4'd2, 1'b1);
        end
        idle_inputs();
        tick();
        chk_cdb("drain1", 1'b1, 32'h62, 4'd3, 1'b0);
        tick();
        chk_cdb("drain2", 1'b1, 32'h72, 4'd4, 1'b1);
        tick();
        chk("drain_idle", 32'(bus.cdbFlag), 32'd0);

        // 7. Flush while readyIn is low still discards queued entries.
        do_reset();
        set_alu(1'b1, 32'h81, 4'd1); set_lsb(1'b1, 32'h91, 4'd2);
        tick();
        set_alu(1'b1, 32'h82, 4'd3); set_lsb(1'b1, 32'h92, 4'd4);
        tick();
        idle_inputs();
        bus.readyIn = 1'b0;
        bus.clearFlag = 1'b1;
        tick();
        idle_inputs();
        chk("flush_lowrdy_flag", 32'(bus.cdbFlag), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("flush_lowrdy_idle", 32'(bus.cdbFlag), 32'd0);
        end

        @(negedge clockIn);
        cmpEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
